// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: fetch, decode, execute, memory, writeback.
// Define CTRL_MEM_TIMEOUT_EN to bound MEM wait cycles and raise mem_err.
module multicycle_controller #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ALUSrc,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               illegal,
  output logic               mem_err,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } st_t;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_LD  = 7'd3;
  localparam logic [6:0] OP_ST  = 7'd35;
  localparam logic [6:0] OP_BR  = 7'd99;
  localparam logic [6:0] OP_LUI = 7'd55;

  st_t        st;
  logic [6:0] op;
  logic       supp;
  logic       is_ld;
  logic       is_st;
  logic       unused_bits;

  assign supp  = op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI};
  assign is_ld = (op == OP_LD);
  assign is_st = (op == OP_ST);
  assign state = st;
  assign unused_bits = ^instr[31:7];

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= FETCH;
      op      <= '0;
      illegal <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
      cnt     <= '0;
      mem_err <= 1'b0;
`endif
    end else begin
      unique case (st)
        FETCH: begin
          if (instr_valid) begin
            op <= instr[6:0];
            st <= DECODE;
          end
        end
        DECODE: begin
          if (supp) begin
            st <= EXEC;
          end else begin
            illegal <= 1'b1;
            st      <= TRAP;
          end
        end
        EXEC: begin
          if (is_ld || is_st) begin
            st <= MEM;
`ifdef CTRL_MEM_TIMEOUT_EN
            cnt <= '0;
`endif
          end else if (op == OP_BR) begin
            st <= FETCH;
          end else begin
            st <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            st <= is_ld ? WB : FETCH;
          end
`ifdef CTRL_MEM_TIMEOUT_EN
          else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
            cnt     <= CW'(MEM_TIMEOUT);
            mem_err <= 1'b1;
            st      <= TRAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WB:      st <= FETCH;
        default: st <= TRAP;
      endcase
    end
  end

  // IR is enabled for all of FETCH; the word captured is the one
  // present on the instr_valid edge, since that edge also leaves FETCH.
  always_comb begin
    ir_write = 1'b0;
    pc_write = 1'b0;
    branch   = 1'b0;
    ALUop    = '0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    unique case (st)
      FETCH: ir_write = 1'b1;
      EXEC: begin
        branch = (op == OP_BR);
        ALUSrc = op inside {OP_I, OP_LD, OP_ST, OP_LUI};
        unique case (1'b1)
          op == OP_R:   ALUop = ALUOP_W'(2);
          op == OP_I:   ALUop = ALUOP_W'(3);
          op == OP_BR:  ALUop = ALUOP_W'(1);
          op == OP_LUI: ALUop = ALUOP_W'(4);
          default:      ALUop = '0;
        endcase
      end
      MEM: begin
        MemRead  = is_ld;
        MemWrite = is_st;
        pc_write = is_st;
      end
      WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        MemToReg = is_ld;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: phase-schedule model plus literal pins.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic        ir_write, pc_write, branch, ALUSrc;
  logic [2:0]  ALUop;
  logic        RegWrite, MemRead, MemWrite, MemToReg;
  logic        illegal, mem_err;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUOP_W(3), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .ALUop(ALUop), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  typedef enum int {PF, PD, PE, PM, PW, PT} ph_t;

  logic [15:0] exp_v;
  logic [15:0] act;
  bit          chk_en = 1'b0;
  string       tag = "";
  int          n_chk = 0;
  int          n_pass = 0;
  int          c_rd, c_wr, c_rw, c_br, c_pcw;
  bit          e_ill = 1'b0;
  bit          e_err = 1'b0;
  int          len;

  assign act = {state, ir_write, pc_write, branch, ALUop, ALUSrc,
                RegWrite, MemRead, MemWrite, MemToReg, illegal, mem_err};

  function automatic logic [15:0] model(input ph_t ph, input logic [6:0] op);
    logic [2:0] sc;
    logic [2:0] alu;
    bit ld, st, src;
    ld  = (op == 7'd3);
    st  = (op == 7'd35);
    sc  = 3'd7;
    alu = 3'd0;
    case (ph)
      PF: sc = 3'd0;
      PD: sc = 3'd1;
      PE: sc = 3'd2;
      PM: sc = 3'd3;
      PW: sc = 3'd4;
      default: sc = 3'd7;
    endcase
    if (ph == PE) begin
      case (op)
        7'd51:  alu = 3'd2;
        7'd19:  alu = 3'd3;
        7'd99:  alu = 3'd1;
        7'd55:  alu = 3'd4;
        default: alu = 3'd0;
      endcase
    end
    src = (ph == PE) && (op inside {7'd19, 7'd3, 7'd35, 7'd55});
    return {sc, ph == PF, (ph == PW) || (ph == PM && st),
            ph == PE && op == 7'd99, alu, src, ph == PW,
            ph == PM && ld, ph == PM && st, ph == PW && ld,
            e_ill, e_err};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp_v);
      c_rd  += int'(MemRead);
      c_wr  += int'(MemWrite);
      c_rw  += int'(RegWrite);
      c_br  += int'(branch);
      c_pcw += int'(pc_write);
    end
  end

  task automatic lit(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, want);
  endtask

  task automatic step(input string nm, input ph_t ph, input logic [6:0] op,
                      input logic [31:0] ins, input bit v, input bit mr);
    @(posedge clk); #1;
    instr = ins;
    instr_valid = v;
    mem_ready = mr;
    exp_v = model(ph, op);
    tag = nm;
    chk_en = 1'b1;
  endtask

  // Build the phase schedule from the latency rules, then play it.
  task automatic run(input string nm, input logic [31:0] ins, input int w,
                     input bit to, output int n);
    ph_t pl[$];
    logic [6:0] op;
    bit sup, last_m;
    op = ins[6:0];
    sup = op inside {7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd55};
    pl.push_back(PF);
    pl.push_back(PD);
    if (!sup) pl.push_back(PT);
    else begin
      pl.push_back(PE);
      if (op == 7'd3 || op == 7'd35) begin
        repeat (to ? 8 : w + 1) pl.push_back(PM);
        if (to) pl.push_back(PT);
        else if (op == 7'd3) pl.push_back(PW);
      end else if (op != 7'd99) pl.push_back(PW);
    end
    n = (pl[$] == PT) ? -1 : pl.size();
    c_rd = 0; c_wr = 0; c_rw = 0; c_br = 0; c_pcw = 0;
    foreach (pl[i]) begin
      last_m = (pl[i] == PM) &&
               (i == pl.size() - 1 || pl[i+1] != PM);
      if (pl[i] == PT) begin
        if (!sup) e_ill = 1'b1;
        else e_err = 1'b1;
      end
      step($sformatf("%s ph%0d c%0d", nm, pl[i], i), pl[i], op,
           (i == 0) ? ins : 32'h0000_007F,
           (i == 0) || (pl[i] != PF),
           (pl[i] != PM) ? 1'b1 : (!to && last_m));
    end
    if (n > 0) step({nm, " done"}, PF, op, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    instr_valid = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    e_ill = 1'b0;
    e_err = 1'b0;
    exp_v = model(PF, 7'd0);
    tag = nm;
    chk_en = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    instr = 32'h0;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_v = model(PF, 7'd0);
    tag = "reset";
    chk_en = 1'b1;
    @(negedge clk); #1;
    lit("reset_state", int'(state), 0);

    run("rtype", 32'h002081B3, 0, 1'b0, len);
    lit("rtype_len", len, 4);
    lit("rtype_regwrite", c_rw, 1);
    lit("rtype_pcwrite", c_pcw, 1);

    run("load", 32'h0000A183, 2, 1'b0, len);
    lit("load_len", len, 7);
    lit("load_memread", c_rd, 3);
    lit("load_regwrite", c_rw, 1);

    run("store", 32'h0030A023, 0, 1'b0, len);
    lit("store_len", len, 4);
    lit("store_memwrite", c_wr, 1);
    lit("store_pcwrite", c_pcw, 1);
    lit("store_regwrite", c_rw, 0);

    run("branch", 32'h00208463, 0, 1'b0, len);
    lit("branch_len", len, 3);
    lit("branch_strobe", c_br, 1);
    lit("branch_pcwrite", c_pcw, 0);

    run("itype", 32'h00108093, 0, 1'b0, len);
    lit("itype_len", len, 4);
    run("lui", 32'h000000B7, 0, 1'b0, len);
    lit("lui_len", len, 4);
    run("store_w3", 32'h0030A023, 3, 1'b0, len);
    lit("store_w3_len", len, 7);
    lit("store_w3_memwrite", c_wr, 4);

`ifdef CTRL_MEM_TIMEOUT_EN
    run("load_to", 32'h0000A183, 0, 1'b1, len);
    lit("timeout_err", int'(mem_err), 1);
    lit("timeout_state", int'(state), 7);
    lit("timeout_memread", c_rd, 8);
    do_reset("reset_after_to");
    run("load_w7", 32'h0000A183, 7, 1'b0, len);
    lit("load_w7_len", len, 12);
    lit("load_w7_err", int'(mem_err), 0);
`else
    run("load_w12", 32'h0000A183, 12, 1'b0, len);
    lit("load_w12_len", len, 17);
    lit("load_w12_err", int'(mem_err), 0);
`endif

    step("abort f", PF, 7'd3, 32'h0000A183, 1'b1, 1'b0);
    step("abort d", PD, 7'd3, 32'h0, 1'b0, 1'b0);
    step("abort e", PE, 7'd3, 32'h0, 1'b0, 1'b0);
    step("abort m0", PM, 7'd3, 32'h0, 1'b0, 1'b0);
    step("abort m1", PM, 7'd3, 32'h0, 1'b0, 1'b0);
    do_reset("reset_mid_mem");
    run("rtype_after", 32'h002081B3, 0, 1'b0, len);
    lit("rtype_after_len", len, 4);

    run("illegal", 32'h0000007F, 0, 1'b0, len);
    c_rd = 0; c_wr = 0; c_rw = 0; c_br = 0; c_pcw = 0;
    for (int i = 0; i < 20; i++) begin
      step("trap_hold", PT, 7'h7F, $urandom, 1'($urandom), 1'($urandom));
    end
    @(negedge clk); #1;
    lit("trap_illegal", int'(illegal), 1);
    lit("trap_strobes", c_rd + c_wr + c_rw + c_br + c_pcw, 0);
    do_reset("reset_from_trap");
    lit("trap_cleared", int'(illegal), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
